counter_bcd_multi: RTL

COUNTER_BCD_MULTI -- requirements
Module: counter_bcd_multi

---
 rtl/counter_bcd_multi.sv | 95 +++++++++
 1 files changed

// File: rtl/counter_bcd_multi.sv
// rtl/counter_bcd_multi.sv - cascaded BCD up/down counter with load clamp, saturation and terminal flags
module counter_bcd_multi #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enablen,
    input  logic                  load,
    input  logic                  up,
    input  logic                  stop,
    input  logic [4*DIGITS-1:0]   in,
    output logic [4*DIGITS-1:0]   count,
    output logic                  rco_L,
    output logic                  done,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] r_count;
    logic                r_done;
    logic                r_load_err;

    logic [4*DIGITS-1:0] w_clamped;
    logic                w_bad_digit;
    logic [4*DIGITS-1:0] w_terminal;
    logic [4*DIGITS-1:0] w_stepped;
    logic                w_carry;
    logic                w_at_terminal;
    logic                w_saturated;
    logic [3:0]          w_digit;

    // Load path: any digit above 9 is forced to 9 so count never holds a non-BCD digit.
    always_comb begin
        w_clamped   = '0;
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (in[4*i +: 4] > 4'd9) begin
                w_clamped[4*i +: 4] = 4'd9;
                w_bad_digit         = 1'b1;
            end else begin
                w_clamped[4*i +: 4] = in[4*i +: 4];
            end
        end
    end

    assign w_terminal    = up ? {DIGITS{4'h9}} : {DIGITS{4'h0}};
    assign w_at_terminal = (r_count == w_terminal);
    assign w_saturated   = stop && w_at_terminal;

    // Ripple carry/borrow: a digit steps only while every lower digit sits at its rollover value.
    always_comb begin
        w_stepped = r_count;
        w_carry   = 1'b1;
        w_digit   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_count[4*i +: 4];
            if (w_carry) begin
                if (up) begin
                    w_stepped[4*i +: 4] = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
                end else begin
                    w_stepped[4*i +: 4] = (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
                end
            end
            w_carry = w_carry && (up ? (w_digit == 4'd9) : (w_digit == 4'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_count    <= w_clamped;
            r_done     <= 1'b0;
            r_load_err <= w_bad_digit;
        end else if (!enablen) begin
            r_load_err <= 1'b0;
            if (w_saturated) begin
                r_done <= 1'b0;
            end else begin
                r_count <= w_stepped;
                r_done  <= (w_stepped == w_terminal);
            end
        end else begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign count    = r_count;
    assign done     = r_done;
    assign load_err = r_load_err;
    assign rco_L    = !w_at_terminal;

endmodule
